// File: rtl/ti_sbox_seq_pkg.sv
// Shared types and helpers for the threshold-implementation S-box sequencer.
// The optional share refresh is enabled with the TI_SBOX_SEQ_REFRESH_EN macro.
package ti_sbox_pkg;

    localparam int SHARE_W = 4;
    localparam int NSHARE  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Share index (j + k) mod 3 for j, k in 0..2.
    function automatic logic [1:0] share_idx(input logic [1:0] j, input logic [1:0] k);
        logic [2:0] s;
        s = {1'b0, j} + {1'b0, k};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/ti_sbox_seq_share_mux.sv
// Operand selector for the component-function bank. Output share j is fed
// only from the two other input shares (non-completeness); the operand is
// forced to zero whenever en_i is low so no share leaks onto the bank.
module ti_share_mux
    import ti_sbox_pkg::*;
(
    input  logic [NSHARE*SHARE_W-1:0] cur_i,
    input  logic [1:0]                j_i,
    input  logic                      en_i,
    output logic [2*SHARE_W-1:0]      sf_in_o
);

    function automatic logic [SHARE_W-1:0] pick(input logic [NSHARE*SHARE_W-1:0] v,
                                                 input logic [1:0] idx);
        case (idx)
            2'd0:    pick = v[3:0];
            2'd1:    pick = v[7:4];
            default: pick = v[11:8];
        endcase
    endfunction

    // High nibble is share j+1, low nibble is share j+2 (both mod 3).
    always_comb begin
        sf_in_o = '0;
        if (en_i) begin
            sf_in_o = {pick(cur_i, share_idx(j_i, 2'd1)), pick(cur_i, share_idx(j_i, 2'd2))};
        end
    end

endmodule

// File: rtl/ti_sbox_seq.sv
// TI S-box sequencer: time-multiplexes one external 8-in/4-out function bank
// over 3 output shares x NSTAGE stages, registering every stage as a glitch
// barrier. Optional share refresh: define TI_SBOX_SEQ_REFRESH_EN.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid, once raised by the producer, is not required to be
// held, and ready never depends combinationally on valid.
module ti_sbox_seq
    import ti_sbox_pkg::*;
#(
    parameter int NSTAGE = 2,
    parameter int SW     = 4
) (
    input  logic            clk,
    input  logic            rst,
`ifdef TI_SBOX_SEQ_REFRESH_EN
    input  logic [7:0]      rnd,
    output logic            rnd_req,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3*SW-1:0] in_shares,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3*SW-1:0] out_shares,
    output logic [1:0]      sf_stage,
    output logic [2*SW-1:0] sf_in,
    input  logic [SW-1:0]   sf_out,
    output logic            busy,
    output logic [1:0]      fsm_state_o
);

    localparam logic [1:0] LAST_STAGE = 2'(NSTAGE - 1);

    state_t          state_q, state_d;
    logic [1:0]      stage_q, stage_d;
    logic [1:0]      j_q, j_d;
    logic [3*SW-1:0] cur_q, cur_d;
    logic [SW-1:0]   nxt0_q, nxt0_d;
    logic [SW-1:0]   nxt1_q, nxt1_d;
    logic [SW-1:0]   w0, w1, w2;

    // Stage write value: refreshed with rnd when enabled, XOR of shares preserved.
`ifdef TI_SBOX_SEQ_REFRESH_EN
    assign w0      = nxt0_q ^ rnd[3:0];
    assign w1      = nxt1_q ^ rnd[7:4];
    assign w2      = sf_out ^ rnd[3:0] ^ rnd[7:4];
    assign rnd_req = (state_q == EVAL) && (j_q == 2'd2);
`else
    assign w0 = nxt0_q;
    assign w1 = nxt1_q;
    assign w2 = sf_out;
`endif

    // Next-state and datapath update for the IDLE/EVAL/DONE sequencer.
    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        j_d     = j_q;
        cur_d   = cur_q;
        nxt0_d  = nxt0_q;
        nxt1_d  = nxt1_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cur_d   = in_shares;
                    stage_d = 2'd0;
                    j_d     = 2'd0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                case (j_q)
                    2'd0: begin
                        nxt0_d = sf_out;
                        j_d    = 2'd1;
                    end
                    2'd1: begin
                        nxt1_d = sf_out;
                        j_d    = 2'd2;
                    end
                    default: begin
                        cur_d = {w2, w1, w0};
                        j_d   = 2'd0;
                        if (stage_q == LAST_STAGE) begin
                            state_d = DONE;
                        end else begin
                            stage_d = stage_q + 2'd1;
                        end
                    end
                endcase
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and share registers; reset clears everything so no partial result survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            stage_q <= 2'd0;
            j_q     <= 2'd0;
            cur_q   <= '0;
            nxt0_q  <= '0;
            nxt1_q  <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            j_q     <= j_d;
            cur_q   <= cur_d;
            nxt0_q  <= nxt0_d;
            nxt1_q  <= nxt1_d;
        end
    end

    ti_share_mux u_mux (
        .cur_i   (cur_q),
        .j_i     (j_q),
        .en_i    (state_q == EVAL),
        .sf_in_o (sf_in)
    );

    assign in_ready    = (state_q == IDLE);
    assign busy        = (state_q == EVAL);
    assign out_valid   = (state_q == DONE);
    assign out_shares  = (state_q == DONE) ? cur_q : '0;
    assign sf_stage    = (state_q == EVAL) ? stage_q : 2'd0;
    assign fsm_state_o = state_q;

endmodule

// File: tb/tb_ti_sbox_seq.sv
// Directed bench for ti_sbox_seq with bank model f(a,b) = a ^ b, NSTAGE = 2.
module tb_ti_sbox_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_shares;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_shares;
    logic [1:0]  sf_stage;
    logic [7:0]  sf_in;
    logic [3:0]  sf_out;
    logic        busy;
    logic [1:0]  fsm_state;
`ifdef TI_SBOX_SEQ_REFRESH_EN
    logic [7:0]  rnd = 8'hA5;
    logic        rnd_req;
`endif

    int checks = 0;
    int errors = 0;

    ti_sbox_seq #(.NSTAGE(2), .SW(4)) dut (
        .clk         (clk),
        .rst         (rst),
`ifdef TI_SBOX_SEQ_REFRESH_EN
        .rnd         (rnd),
        .rnd_req     (rnd_req),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_shares   (in_shares),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_shares  (out_shares),
        .sf_stage    (sf_stage),
        .sf_in       (sf_in),
        .sf_out      (sf_out),
        .busy        (busy),
        .fsm_state_o (fsm_state)
    );

    // Function bank model.
    assign sf_out = sf_in[7:4] ^ sf_in[3:0];

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present shares for one cycle; returns at the first EVAL cycle's negedge.
    task automatic do_handshake(input logic [11:0] shares);
        in_valid  = 1'b1;
        in_shares = shares;
        @(negedge clk);
        in_valid  = 1'b0;
    endtask

    // Bounded wait for out_valid; n counts cycles after the first EVAL cycle.
    task automatic wait_valid(input int budget, output int n);
        n = 0;
        while (!out_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},   {31'd0, in_ready},  32'd1);
        check({tag, "_out_valid"},  {31'd0, out_valid}, 32'd0);
        check({tag, "_busy"},       {31'd0, busy},      32'd0);
        check({tag, "_out_shares"}, {20'd0, out_shares}, 32'h0);
        check({tag, "_sf_stage"},   {30'd0, sf_stage},  32'd0);
        check({tag, "_sf_in"},      {24'd0, sf_in},     32'h0);
        check({tag, "_state"},      {30'd0, fsm_state}, 32'd0);
    endtask

    logic [7:0] exp_sf [6];
    int         n, cnt, p1, p2, req_cnt;
    logic [11:0] v1, v2;

    initial begin
        // Hand-derived operands for shares {4,2,1}: stage 0 then stage 1.
`ifdef TI_SBOX_SEQ_REFRESH_EN
        exp_sf = '{8'h24, 8'h41, 8'h12, 8'hFC, 8'hC3, 8'h3F};
`else
        exp_sf = '{8'h24, 8'h41, 8'h12, 8'h53, 8'h36, 8'h65};
`endif
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_shares = 12'h000;
        out_ready = 1'b1;
        req_cnt   = 0;

        // Reset values.
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("idle");

        // Main run: 0x421 -> 0x356, operand sequence, latency 7.
        do_handshake(12'h421);
        for (int k = 0; k < 6; k++) begin
            if (k > 0) @(negedge clk);
            check("eval_busy",     {31'd0, busy},      32'd1);
            check("eval_in_ready", {31'd0, in_ready},  32'd0);
            check("eval_out_vld",  {31'd0, out_valid}, 32'd0);
            check("eval_sf_stage", {30'd0, sf_stage},  k / 3);
            check($sformatf("eval_sf_in_%0d", k), {24'd0, sf_in}, {24'd0, exp_sf[k]});
`ifdef TI_SBOX_SEQ_REFRESH_EN
            if (rnd_req) req_cnt++;
`endif
        end
        @(negedge clk);
        check("done_out_valid",  {31'd0, out_valid}, 32'd1);
        check("done_out_shares", {20'd0, out_shares}, 32'h356);
        check("done_sf_in",      {24'd0, sf_in},     32'h0);
        check("done_in_ready",   {31'd0, in_ready},  32'd0);
`ifdef TI_SBOX_SEQ_REFRESH_EN
        check("refresh_req_cnt", req_cnt, 32'd2);
        check("refresh_xor", {28'd0, out_shares[11:8] ^ out_shares[7:4] ^ out_shares[3:0]}, 32'h0);
`endif
        @(negedge clk);
        check("back_idle_ready", {31'd0, in_ready},  32'd1);
        check("back_idle_vld",   {31'd0, out_valid}, 32'd0);

        // DONE held with out_ready low: stable output, in_valid ignored.
        out_ready = 1'b0;
        do_handshake(12'h9C3);
        wait_valid(20, n);
        check("hold_latency", n + 1, 32'd7);
        for (int k = 0; k < 5; k++) begin
            in_valid  = k[0];
            in_shares = 12'h777;
            @(negedge clk);
            check("hold_out_valid",  {31'd0, out_valid}, 32'd1);
            check("hold_out_shares", {20'd0, out_shares}, 32'hFA5);
            check("hold_in_ready",   {31'd0, in_ready},  32'd0);
            check("hold_busy",       {31'd0, busy},      32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("release_out_valid", {31'd0, out_valid}, 32'd0);
        check("release_in_ready",  {31'd0, in_ready},  32'd1);
        @(negedge clk);
        check("release_single_xfer", {31'd0, out_valid}, 32'd0);
        check("release_no_eval",     {31'd0, busy},      32'd0);

        // Reset on the third EVAL cycle.
        do_handshake(12'h421);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_rst");
        do_handshake(12'h421);
        wait_valid(20, n);
        check("post_rst_latency", n + 1, 32'd7);
        check("post_rst_result",  {20'd0, out_shares}, 32'h356);
        @(negedge clk);

        // Back-to-back inputs, out_ready tied high.
        cnt = 0; p1 = 0; p2 = 0; v1 = '0; v2 = '0;
        in_valid  = 1'b1;
        in_shares = 12'h421;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk);
            if (out_valid) begin
                cnt++;
                if (cnt == 1) begin p1 = k; v1 = out_shares; end
                if (cnt == 2) begin p2 = k; v2 = out_shares; end
            end
            if (k == 1) in_shares = 12'h9C3;
            if (k == 9) in_valid = 1'b0;
        end
        check("b2b_count",  cnt, 32'd2);
        check("b2b_first",  p1,  32'd7);
        check("b2b_gap",    p2 - p1, 32'd8);
        check("b2b_val1",   {20'd0, v1}, 32'h356);
        check("b2b_val2",   {20'd0, v2}, 32'hFA5);
        check("b2b_idle",   {31'd0, in_ready}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ti_sbox_seq.md
Name: ti_sbox_seq

Overview:
- Sequencer for a threshold-implementation (TI) 4-bit S-box built from 8-input coordinate-share functions.
- One external component-function bank (4 output bits, 8 input bits) is time-multiplexed over 3 output shares × NSTAGE decomposition stages.
- All three shares of a stage are registered before the next stage starts, so each stage boundary is a glitch barrier.
- Sits between the masked state register and the round datapath of the TI cipher core, with valid/ready on both sides.

Parameters:
- NSTAGE, 2, number of decomposition stages evaluated in sequence (1..4).
- SW, 4, share width in bits; fixed at 4 for this S-box family.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input shares valid.
- in_ready  out  1  block can accept input.
- in_shares  in  12  {s2,s1,s0}, 4 bits each.
- out_valid  out  1  result shares valid.
- out_ready  in  1  consumer accepts result.
- out_shares  out  12  {s2,s1,s0} after the final stage.
- sf_stage  out  2  stage index presented to the function bank.
- sf_in  out  8  function-bank operand.
- sf_out  in  4  function-bank result, combinational from sf_stage/sf_in.
- busy  out  1  high in EVAL.

Behaviour:
- Reset values:
  - FSM = IDLE; in_ready=1; out_valid=0; busy=0.
  - out_shares=0, sf_stage=0, sf_in=0.
  - Share registers cur[0..2]=0, nxt[0..1]=0, stage counter=0, share counter j=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid & in_ready: load cur from in_shares, set stage=0, j=0, go to EVAL.
  - EVAL: in_ready=0, busy=1. Each cycle:
    - sf_stage=stage.
    - sf_in[7:4]=cur[(j+1)%3], sf_in[3:0]=cur[(j+2)%3]. This is the non-completeness rule: output share j never sees input share j.
    - j=0 captures sf_out into nxt[0]; j=1 captures into nxt[1].
    - j=2 writes cur <= {sf_out, nxt[1], nxt[0]} and sets j=0. If stage==NSTAGE-1, go to DONE; otherwise increment stage.
  - DONE: out_valid=1, out_shares={cur[2],cur[1],cur[0]}. Return to IDLE on out_ready; otherwise hold out_shares stable.
- Latency:
  - Handshake at cycle T gives EVAL cycles T+1..T+3·NSTAGE.
  - out_valid is high from T+3·NSTAGE+1.
  - Throughput is one S-box every 3·NSTAGE+2 cycles with out_ready tied high, since in_ready reasserts the cycle after the DONE handshake.
- sf_in is driven 0 in IDLE and DONE. No share value may appear on the bank outside EVAL.
- in_valid during EVAL or DONE is ignored; in_ready=0 in those states.
- out_ready while not in DONE has no effect.
- Reset asserted mid-EVAL or in DONE returns everything to reset values immediately. A partially evaluated result is never presented.
- No combinational path from in_* to out_*. sf_in depends only on registers.

Optional Feature:
- Macro: TI_SBOX_SEQ_REFRESH_EN.
- With the macro defined:
  - Extra ports: rnd (in, 8) and rnd_req (out, 1).
  - rnd_req pulses high on every j=2 cycle of EVAL.
  - The stage write becomes cur <= {sf_out ^ rnd[3:0] ^ rnd[7:4], nxt[1] ^ rnd[7:4], nxt[0] ^ rnd[3:0]}, which preserves the unshared value.
  - rnd is sampled in that same cycle.
- Without the macro: no rnd or rnd_req ports, and no refresh is applied.

Decomposition:
- Package ti_sbox_pkg holds:
  - The state enum (IDLE, EVAL, DONE).
  - Constants SHARE_W=4 and NSHARE=3.
  - A share-index helper function giving (j+k) mod 3.
- One sub-module: ti_share_mux. It is purely combinational and produces sf_in from cur and j.

Test Plan:
- Bench bank model f(a,b)=a^b, NSTAGE=2, in_shares=0x421, out_ready=1:
  - out_shares=0x356.
  - out_valid exactly 7 cycles after the input handshake.
  - in_ready low in between.
- Non-completeness check: on every EVAL cycle, sf_in never contains cur[j]. Check with distinct shares 0x1/0x2/0x4 over all j and both stages.
- out_ready held low 5 cycles in DONE: out_shares stable; in_ready stays 0; in_valid pulses ignored. Release gives one transfer, then IDLE.
- rst pulsed on the 3rd EVAL cycle: all outputs at reset values asynchronously. Next accepted input 0x421 still yields 0x356.
- Back-to-back inputs with out_ready=1: second result is 8 cycles after the first, with no lost or duplicated output.
- With TI_SBOX_SEQ_REFRESH_EN, rnd=0xA5:
  - XOR of the three output shares equals the unrefreshed case.
  - rnd_req pulses exactly twice per evaluation.
